// File: rtl/c17_sig_compactor.sv
// Multiple-input signature register (MISR) that compacts LEN two-bit C17 responses per run.
// Optional golden comparison is built when C17_SIG_COMPARE_EN is defined.
module c17_sig_compactor #(
    parameter int               LEN   = 32,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             po0,
    input  logic             po1,
`ifdef C17_SIG_COMPARE_EN
    input  logic [SIG_W-1:0] golden,
    output logic             pass,
`endif
    output logic             busy,
    output logic             done,
    output logic [15:0]      count,
    output logic [SIG_W-1:0] signature
);

    // Handshake: a vector is taken on a rising edge when in_valid=1 and the FSM is in RUN;
    // there is no back-pressure, vectors offered outside RUN are dropped.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LEN_C = 16'(LEN);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             load;
    logic             last;
    logic [15:0]      count_inc;
    logic [SIG_W-1:0] sig_next;

    assign accept    = (state == RUN) && in_valid;
    assign load      = (state != RUN) && start;
    assign count_inc = count + 16'd1;
    assign last      = (count_inc == LEN_C);

    // Shift left, fold the old MSB back through POLY, then inject the response pair.
    assign sig_next = {signature[SIG_W-2:0], 1'b0}
                    ^ (signature[SIG_W-1] ? POLY : {SIG_W{1'b0}})
                    ^ {{(SIG_W-2){1'b0}}, po1, po0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && last) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
`ifdef C17_SIG_COMPARE_EN
        pass = (state == DONE) && (signature == golden);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signature <= SEED;
            count     <= 16'd0;
        end else if (load) begin
            signature <= SEED;
            count     <= 16'd0;
        end else if (accept) begin
            signature <= sig_next;
            count     <= count_inc;
        end
    end

endmodule

// File: tb/tb_c17_sig_compactor.sv
// Bench for c17_sig_compactor: three instances (LEN=4,2,1) share one stimulus stream and are
// checked against a queue-based model that refolds each run's accepted vectors from SEED.
module tb_c17_sig_compactor;

    localparam logic [15:0] POLY = 16'h1021;
    localparam logic [15:0] SEED = 16'hFFFF;
    localparam int          N    = 3;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        po0;
    logic        po1;
    logic        busy_o [N];
    logic        done_o [N];
    logic [15:0] cnt_o  [N];
    logic [15:0] sig_o  [N];
`ifdef C17_SIG_COMPARE_EN
    logic [15:0] golden;
    logic        pass_o [N];
`endif

    int          errors = 0;
    int          checks = 0;
    int          lens   [N] = '{4, 2, 1};
    int          phase  [N];
    logic [1:0]  vq     [N][$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    c17_sig_compactor #(.LEN(4), .SIG_W(16), .POLY(POLY), .SEED(SEED)) u_len4 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .po0(po0), .po1(po1),
`ifdef C17_SIG_COMPARE_EN
        .golden(golden), .pass(pass_o[0]),
`endif
        .busy(busy_o[0]), .done(done_o[0]), .count(cnt_o[0]), .signature(sig_o[0]));

    c17_sig_compactor #(.LEN(2), .SIG_W(16), .POLY(POLY), .SEED(SEED)) u_len2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .po0(po0), .po1(po1),
`ifdef C17_SIG_COMPARE_EN
        .golden(golden), .pass(pass_o[1]),
`endif
        .busy(busy_o[1]), .done(done_o[1]), .count(cnt_o[1]), .signature(sig_o[1]));

    c17_sig_compactor #(.LEN(1), .SIG_W(16), .POLY(POLY), .SEED(SEED)) u_len1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .po0(po0), .po1(po1),
`ifdef C17_SIG_COMPARE_EN
        .golden(golden), .pass(pass_o[2]),
`endif
        .busy(busy_o[2]), .done(done_o[2]), .count(cnt_o[2]), .signature(sig_o[2]));

    // ---------------- reference model ----------------
    // phase: 0 = no run, 1 = collecting, 2 = run complete
    function automatic logic [15:0] fold(int k);
        logic [15:0] s;
        s = SEED;
        for (int i = 0; i < vq[k].size(); i++) begin
            s = {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0000) ^ {14'b0, vq[k][i]};
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            phase[k] = 0;
            vq[k].delete();
        end
    endtask

    task automatic model_edge(input logic s, input logic v, input logic [1:0] p);
        for (int k = 0; k < N; k++) begin
            if (phase[k] != 1 && s) begin
                vq[k].delete();
                phase[k] = 1;
            end else if (phase[k] == 1 && v) begin
                vq[k].push_back(p);
                if (vq[k].size() == lens[k]) phase[k] = 2;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_all();
        for (int k = 0; k < N; k++) begin
            checks++;
            assert (sig_o[k] === fold(k))
            else begin errors++; $error("FAIL sig[%0d] got %h exp %h", k, sig_o[k], fold(k)); end
            checks++;
            assert (cnt_o[k] === 16'(vq[k].size()))
            else begin errors++; $error("FAIL cnt[%0d] got %0d exp %0d", k, cnt_o[k], vq[k].size()); end
            checks++;
            assert (busy_o[k] === (phase[k] == 1))
            else begin errors++; $error("FAIL busy[%0d] got %b exp %b", k, busy_o[k], phase[k] == 1); end
            checks++;
            assert (done_o[k] === (phase[k] == 2))
            else begin errors++; $error("FAIL done[%0d] got %b exp %b", k, done_o[k], phase[k] == 2); end
`ifdef C17_SIG_COMPARE_EN
            checks++;
            assert (pass_o[k] === (phase[k] == 2 && fold(k) == golden))
            else begin errors++; $error("FAIL pass[%0d] got %b exp %b", k, pass_o[k],
                                        phase[k] == 2 && fold(k) == golden); end
`endif
        end
    endtask

    task automatic check_const(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp)
        else begin errors++; $error("FAIL %s got %h exp %h", tag, got, exp); end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic s, input logic v, input logic [1:0] p);
        start    = s;
        in_valid = v;
        {po1, po0} = p;
        @(posedge clk);
        model_edge(s, v, p);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check_all();
    endtask

    // Assert rst between edges and check outputs before the next rising edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;
        check_all();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; po0 = 1'b0; po1 = 1'b0;
`ifdef C17_SIG_COMPARE_EN
        golden = 16'hEFDF;
`endif
        model_reset();
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;

        // Idle with toggling in_valid: nothing may move.
        for (int i = 0; i < 10; i++) step(1'b0, i[0], 2'($urandom_range(0, 3)));
        check_const("idle_sig", sig_o[0], 16'hFFFF);

        // LEN=1 runs: 00 then 11; LEN=4 ignores the second start.
        step(1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b1, 2'b00);
        check_const("len1_sig00", sig_o[2], 16'hEFDF);
        check_const("len1_done", 16'(done_o[2]), 16'h0001);
`ifdef C17_SIG_COMPARE_EN
        check_const("pass_match", 16'(pass_o[2]), 16'h0001);
        golden = 16'h0000;
        #1 check_const("pass_mismatch", 16'(pass_o[2]), 16'h0000);
        golden = 16'hEFDF;
`endif
        step(1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b1, 2'b11);
        check_const("len1_sig11", sig_o[2], 16'hEFDC);

        // LEN=2: 00, three idle cycles, 00.
        step(1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b11);
        check_const("len2_not_done", 16'(done_o[1]), 16'h0000);
        step(1'b0, 1'b1, 2'b00);
        check_const("len2_sig", sig_o[1], 16'hCF9F);
        check_const("len1_held", sig_o[2], 16'hEFDF);

        // Async reset after two vectors, then a full fresh LEN=4 run.
        step(1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b1, 2'b01);
        step(1'b0, 1'b1, 2'b10);
        async_reset();
        check_const("rst_sig", sig_o[0], 16'hFFFF);
        step(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'($urandom_range(0, 3)));
        check_const("len4_cnt", cnt_o[0], 16'd4);
        check_const("len4_done", 16'(done_o[0]), 16'h0001);

        // Randomized traffic with occasional starts and mid-cycle resets.
        for (int i = 0; i < 400; i++) begin
`ifdef C17_SIG_COMPARE_EN
            golden = ($urandom_range(0, 1) == 0) ? fold(0) : 16'($urandom_range(0, 65535));
`endif
            if ($urandom_range(0, 60) == 0) async_reset();
            else step($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/c17_sig_compactor.md
C17_SIG_COMPACTOR -- requirements
Module: c17_sig_compactor

Interface
REQ-001 The module SHALL have parameter LEN, default 32, giving the number of response vectors compacted per run (1..65535).
REQ-002 The module SHALL have parameter SIG_W, default 16, giving the signature width (>= 4).
REQ-003 The module SHALL have parameter POLY, default 16'h1021, giving the MISR feedback polynomial (SIG_W bits).
REQ-004 The module SHALL have parameter SEED, default 16'hFFFF, giving the signature value loaded at reset and at start (SIG_W bits).
REQ-005 Port clk  input  1  is the single clock; all state SHALL change on its rising edge.
REQ-006 Port rst  input  1  is the reset; it SHALL be asynchronous and active-high.
REQ-007 Port start  input  1  SHALL be a single-cycle pulse beginning a run.
REQ-008 Port in_valid  input  1  SHALL qualify po0/po1 as one response vector this cycle.
REQ-009 Port po0  input  1  SHALL carry response bit 0 from the C17 stage.
REQ-010 Port po1  input  1  SHALL carry response bit 1 from the C17 stage.
REQ-011 Port busy  output  1  SHALL be high while in state RUN.
REQ-012 Port done  output  1  SHALL be high while in state DONE.
REQ-013 Port count  output  16  SHALL give the number of vectors accepted in the current run.
REQ-014 Port signature  output  SIG_W  SHALL give the current MISR register value.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE and DONE, start=1 SHALL load signature=SEED and count=0 and enter RUN next cycle.
REQ-017 In IDLE and DONE, in_valid SHALL be ignored.
REQ-018 In RUN, in_valid=1 SHALL update signature as follows: shifted = signature<<1 (LSB 0); XOR with POLY if the old signature MSB=1; XOR with {0...,po1,po0}.
REQ-019 In RUN, in_valid=1 SHALL increment count by 1, with the signature and count update taking effect at the same edge.
REQ-020 When the accepted vector makes count equal LEN, the FSM SHALL enter DONE at that same edge (busy low, done high the next cycle).
REQ-021 In DONE, signature and count SHALL hold until the next start or reset.
REQ-022 In RUN, start SHALL be ignored.
REQ-023 In RUN, in_valid=0 SHALL hold all state.
REQ-024 Latency SHALL be one cycle: an accepted vector is reflected in signature on the cycle after the edge that samples it.
REQ-025 count SHALL never exceed LEN and SHALL not wrap.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, signature=SEED, count=0, busy=0 and done=0, regardless of clock.
REQ-027 Reset asserted mid-run SHALL discard the partial signature, and no done pulse SHALL be produced.

Configuration
REQ-028 With macro C17_SIG_COMPARE_EN defined, the module SHALL add input golden (SIG_W bits) and output pass (1 bit); pass SHALL equal (signature==golden) while done=1, and 0 otherwise and at reset.
REQ-029 Without C17_SIG_COMPARE_EN defined, the golden and pass ports SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-030 Release reset with no start -> signature=16'hFFFF, count=0, busy=0, done=0 held for 10 cycles despite in_valid toggling.
REQ-031 LEN=1, start, then one vector po1=0 po0=0 -> signature=16'hEFDF, count=1, done=1; repeat the run with po1=1 po0=1 -> 16'hEFDC.
REQ-032 LEN=2, vectors 00 then 00 with 3 idle cycles (in_valid=0) between them -> signature=16'hCF9F, done asserted only after the second vector.
REQ-033 LEN=4, rst asserted asynchronously after 2 vectors -> outputs return to reset values before the next clock edge; a fresh start runs a full 4-vector run.
REQ-034 start pulsed during RUN, and in_valid asserted in DONE -> no change to count or signature.
REQ-035 With C17_SIG_COMPARE_EN, LEN=1, golden=16'hEFDF, vector 00 -> pass=1; golden=16'h0000 -> pass=0; pass=0 before done.
